// File: rtl/div_arbiter_ctrl.sv
`timescale 1ns/1ps
// div_arbiter_ctrl
//
// Shares a single Division_BLOCK between two requester ports. Requests are
// arbitrated round-robin, operands are latched and handed to the divider with
// a one-cycle start pulse, and the tagged result is returned to the owning
// port under valid/ready back-pressure. Kill and a BUSY watchdog keep the
// shared divider recoverable without ever aborting a division in flight.
//
// Ports (slice i of every packed per-port vector belongs to port i):
//   CLK, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake, one bit per port
//   req_op                   2 bits per port: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   req_rs1/req_rs2          dividend / divisor, XLEN bits per port
//   req_tag                  TAG_W bits per port, echoed on the response
//   kill                     discard the port's outstanding operation
//   rsp_valid/rsp_ready      response handshake, one bit per port
//   rsp_data/tag/dbz/err     shared response payload, qualified by rsp_valid
//   div_dividend/divisor/operation/data_valid   request side of the divider
//   div_product/divided_by_zero/data_ready      result side of the divider
module div_arbiter_ctrl #(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 40
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [3:0]           req_op,
    input  logic [2*XLEN-1:0]    req_rs1,
    input  logic [2*XLEN-1:0]    req_rs2,
    input  logic [2*TAG_W-1:0]   req_tag,
    input  logic [1:0]           kill,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [XLEN-1:0]      rsp_data,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic                 rsp_dbz,
    output logic                 rsp_err,
    output logic [XLEN-1:0]      div_dividend,
    output logic [XLEN-1:0]      div_divisor,
    output logic [1:0]           div_operation,
    output logic                 div_data_valid,
    input  logic [XLEN-1:0]      div_product,
    input  logic                 div_divided_by_zero,
    input  logic                 div_data_ready
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

    state_t             state;
    state_t             state_next;
    logic               ptr;
    logic               owner;
    logic               killed;
    logic [TAG_W-1:0]   tag_q;
    logic [CNT_W-1:0]   count;

    logic               grant;
    logic               accept;
    logic               kill_owner;
    logic               rsp_ready_owner;
    logic               timed_out;
    logic               drop;
    logic               done;

    // The priority pointer only matters when both ports ask at once;
    // otherwise the single requester wins.
    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b11) begin
            grant = ptr;
        end else if (req_valid[1]) begin
            grant = 1'b1;
        end
        req_ready = ((state == IDLE) && (req_valid != 2'b00)) ? {grant, ~grant} : 2'b00;
    end

    assign accept          = (req_valid & req_ready) != 2'b00;
    assign kill_owner      = owner ? kill[1] : kill[0];
    assign rsp_ready_owner = owner ? rsp_ready[1] : rsp_ready[0];
    assign timed_out       = (count == CNT_W'(TIMEOUT - 1));
    assign done            = div_data_ready || timed_out;
    // A kill arriving in the same cycle as completion still suppresses the response.
    assign drop            = killed || kill_owner;

    always_ff @(posedge CLK) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   state_next = BUSY;
            BUSY:    if (done) state_next = drop ? IDLE : RESP;
            RESP:    if (rsp_ready_owner || kill_owner) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand/response registers. The divider's result is only looked at in
    // BUSY, so a stale data_ready after reset or kill cannot leak through.
    always_ff @(posedge CLK) begin
        if (rst) begin
            ptr            <= 1'b0;
            owner          <= 1'b0;
            killed         <= 1'b0;
            tag_q          <= '0;
            count          <= '0;
            div_dividend   <= '0;
            div_divisor    <= '0;
            div_operation  <= 2'b00;
            div_data_valid <= 1'b0;
            rsp_valid      <= 2'b00;
            rsp_data       <= '0;
            rsp_tag        <= '0;
            rsp_dbz        <= 1'b0;
            rsp_err        <= 1'b0;
        end else begin
            div_data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner          <= grant;
                        ptr            <= ~grant;
                        killed         <= 1'b0;
                        div_dividend   <= grant ? req_rs1[2*XLEN-1:XLEN] : req_rs1[XLEN-1:0];
                        div_divisor    <= grant ? req_rs2[2*XLEN-1:XLEN] : req_rs2[XLEN-1:0];
                        div_operation  <= grant ? req_op[3:2] : req_op[1:0];
                        tag_q          <= grant ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
                        div_data_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    count <= '0;
                    if (kill_owner) killed <= 1'b1;
                end
                BUSY: begin
                    count <= count + 1'b1;
                    if (kill_owner) killed <= 1'b1;
                    if (done) begin
                        rsp_tag <= tag_q;
                        if (div_data_ready) begin
                            rsp_data <= div_product;
                            rsp_dbz  <= div_divided_by_zero;
                            rsp_err  <= 1'b0;
                        end else begin
                            rsp_data <= '0;
                            rsp_dbz  <= 1'b0;
                            rsp_err  <= 1'b1;
                        end
                        if (!drop) rsp_valid <= owner ? 2'b10 : 2'b01;
                    end
                end
                RESP: begin
                    if (rsp_ready_owner || kill_owner) rsp_valid <= 2'b00;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/div_arbiter_ctrl.md
# div_arbiter_ctrl

Sequencing controller that shares one `Division_BLOCK` between two requester ports, such as the integer pipe and a second issue slot. It arbitrates requests round-robin and latches the operands. It then fires a single `data_valid` pulse into the divider and waits for `data_ready`, and returns the tagged result to the owning port with valid/ready back-pressure. Kill and watchdog-timeout paths keep the shared unit recoverable without aborting an in-flight division.

## Interface
Parameters:
- `XLEN` — 32 — operand/result width
- `TAG_W` — 5 — requester tag width (destination register index)
- `TIMEOUT` — 40 — max cycles in BUSY before forced error response; must be ≥ divider latency + 2

Ports (port index i ∈ {0,1}; packed vectors, slice i belongs to port i):
- `CLK`  in  1  — single clock, all logic on rising edge
- `rst`  in  1  — synchronous, active-high reset
- `req_valid`  in  2  — request present
- `req_ready`  out  2  — request accepted this cycle when `req_valid[i]` is also high
- `req_op`  in  4  — 2 bits per port: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- `req_rs1` / `req_rs2`  in  2×XLEN each — dividend / divisor
- `req_tag`  in  2×TAG_W  — echoed on the response
- `kill`  in  2  — discard port i's outstanding operation
- `rsp_valid`  out  2 — response available; `rsp_ready`  in  2 — response consumed
- `rsp_data`  out  XLEN — shared by both ports; qualified by `rsp_valid`
- `rsp_tag`  out  TAG_W — shared; qualified by `rsp_valid`
- `rsp_dbz`  out  1 — divide-by-zero flag; qualified by `rsp_valid`
- `rsp_err`  out  1 — timeout flag; qualified by `rsp_valid`
- `div_dividend`, `div_divisor`  out  XLEN — to divider, registered, stable from ISSUE through BUSY
- `div_operation`  out  2 — to divider
- `div_data_valid`  out  1 — one-cycle start pulse
- `div_product`  in  XLEN; `div_divided_by_zero`  in  1; `div_data_ready`  in  1 — from divider; `div_data_ready` is a one-cycle pulse

## Operation
- FSM states: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - `req_ready[g]=1` only for the granted port g.
  - g = the single valid port, or the priority port when both are valid.
  - On handshake: latch op/rs1/rs2/tag, set `owner=g`, clear `killed`, go to ISSUE.
- ISSUE: exactly one cycle with `div_data_valid=1`; clear the timeout counter; go to BUSY.
- BUSY:
  - Timeout counter increments each cycle.
  - `div_data_ready` high: capture `div_product` and `div_divided_by_zero`, set `err=0`. Go to RESP, or to IDLE if `killed`.
  - Counter reaching TIMEOUT without `div_data_ready`: set `data=0`, `dbz=0`, `err=1`. Go to RESP, or to IDLE if `killed`.
  - `div_data_ready` in any other state is ignored.
- RESP: `rsp_valid[owner]=1` and the data/tag/flags are held stable until `rsp_ready[owner]`; then go to IDLE.
- Priority pointer:
  - Reset value 0.
  - After each grant to port g, the pointer becomes 1−g. A requester is never starved beyond one other operation.
- Kill:
  - `kill[owner]` in ISSUE or BUSY sets `killed`. The divider still runs to completion and its result is dropped; no response is issued.
  - `kill[owner]` in RESP drops `rsp_valid` the next cycle and returns to IDLE.
  - `kill` for a non-owner port, or in IDLE, has no effect.
  - Kill and `rsp_ready` in the same RESP cycle: treated as a consume; return to IDLE.
- The controller never alters results: sign handling and the divide-by-zero value come from the divider.

## Timing
- Reset values: `req_ready=0`, `rsp_valid=0`, `div_data_valid=0`, `rsp_data=0`, `rsp_tag=0`, `rsp_dbz=0`, `rsp_err=0`, `div_*` operands 0, state IDLE, pointer 0.
- `rst` asserted mid-operation: immediate return to IDLE with the outputs above. The in-flight divider result is ignored, because `div_data_ready` is ignored outside BUSY.
- Cycle sequence:
  - Accept at cycle 0.
  - `div_data_valid` at cycle 1.
  - `div_data_ready` at cycle k (k≥2).
  - `rsp_valid` from cycle k+1.
  - Earliest next accept is the cycle after the `rsp_ready` handshake.
- Back-to-back throughput: one operation per (divider latency + 3) cycles when `rsp_ready` is tied high.
- `req_ready` is combinational from state, pointer and `req_valid`. All other outputs are registered.

## Test plan
- After reset, port 0 DIV rs1=−7 (0xFFFFFFF9), rs2=3, tag 5 → one `div_data_valid` pulse; `rsp_valid[0]` with data 0xFFFFFFFE, tag 5, dbz=0, err=0.
- Both ports valid in the same cycle (p0 REM 149/−2, p1 DIVU 25/3) → p0 served first (data 1), then p1 (data 8). Repeat both valid again → p0 served first again, since the pointer returned to 0 after granting p1.
- Port 1 REMU 5/0 → rsp data 5, dbz=1, err=0.
- Port 0 DIV 149/−5 with `kill[0]` pulsed in BUSY → no `rsp_valid`. The FSM reaches IDLE one cycle after `div_data_ready`, and the next request is accepted normally.
- Divider model never asserts `div_data_ready` → after TIMEOUT (40) BUSY cycles, `rsp_valid` with err=1, data 0.
- `rsp_ready` held low for 10 cycles in RESP → `rsp_valid`, data and tag held constant. `req_ready` stays 0 for both ports until the handshake.
